// File: rtl/im_arb_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
//   port_e        : identifies a requester (fetch or loader)
//   *_DEF         : default parameter values used by the interface and modules
package im_arb_pkg;

  localparam int unsigned ADDR_W_DEF    = 10;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_L = 1'b1
  } port_e;

endpackage

// File: rtl/im_arbiter_if.sv
// Bus bundle between the fetch stage, the loader/debug port, the arbiter and
// the instruction memory array.
//   slave  : arbiter view (requests/addresses/im_rdata in; grants, read data,
//            memory address/write lines out)
//   master : environment view (requesters plus memory array)
interface im_arbiter_if
  import im_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic [ADDR_W-1:0] im_addr;
  logic              im_we;
  logic [DATA_W-1:0] im_wdata;
  logic [DATA_W-1:0] im_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, im_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           im_addr, im_we, im_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, im_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           im_addr, im_we, im_wdata
  );

endinterface

// File: rtl/im_arb_core.sv
// Grant decision for the two instruction-memory requesters.
// Last-owner-sticky arbitration: under contention the last granted port keeps
// the memory until it has had MAX_BURST consecutive grants.
//   clk, reset    : clock, asynchronous active-low reset
//   f_req, l_req  : requests from fetch and loader
//   f_gnt, l_gnt  : combinational one-hot (or none) grants
module im_arb_core
  import im_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic f_req,
  input  logic l_req,
  output logic f_gnt,
  output logic l_gnt
);

  localparam int unsigned        CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  port_e            last;
  port_e            gnt_port;
  logic [CNT_W-1:0] cnt;
  logic             keep_last;

  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    keep_last = (cnt < CNT_MAX);
    // No grants while reset is held so the memory sees no access.
    if (reset) begin
      if (f_req && l_req) begin
        // F wins when it is the owner with burst left, or L is exhausted.
        if ((last == PORT_F) == keep_last) f_gnt = 1'b1;
        else                               l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end
    gnt_port = l_gnt ? PORT_L : PORT_F;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= PORT_F;
      cnt  <= '0;
    end else if (f_gnt || l_gnt) begin
      if (gnt_port == last) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      end else begin
        last <= gnt_port;
        cnt  <= CNT_ONE;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/im_arbiter.sv
// Shares the single-ported instruction memory between the fetch stage (F,
// read-only) and the loader/debug port (L, read/write). One access per cycle;
// read data is registered and returned one cycle after the grant.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : im_arbiter_if slave modport (requesters + memory lines)
module im_arbiter
  import im_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input logic           clk,
  input logic           reset,
  im_arbiter_if.slave   bus
);

  logic              f_gnt;
  logic              l_gnt;
  logic              l_rd;
  logic [ADDR_W-1:0] im_addr;
  logic              im_we;
  logic [DATA_W-1:0] im_wdata;
  logic              f_rvalid;
  logic              l_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic [DATA_W-1:0] l_rdata;

  im_arb_core #(
    .MAX_BURST (MAX_BURST)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .f_req (bus.f_req),
    .l_req (bus.l_req),
    .f_gnt (f_gnt),
    .l_gnt (l_gnt)
  );

  assign l_rd = l_gnt && !bus.l_we;

  // Memory lines are forced to zero whenever nobody is granted.
  always_comb begin
    im_addr  = '0;
    im_we    = 1'b0;
    im_wdata = '0;
    if (f_gnt) begin
      im_addr  = bus.f_addr;
      im_wdata = bus.l_wdata;
    end else if (l_gnt) begin
      im_addr  = bus.l_addr;
      im_we    = bus.l_we;
      im_wdata = bus.l_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      f_rdata  <= '0;
      l_rdata  <= '0;
    end else begin
      f_rvalid <= f_gnt;
      l_rvalid <= l_rd;
      if (f_gnt) f_rdata <= bus.im_rdata;
      if (l_rd)  l_rdata <= bus.im_rdata;
    end
  end

  assign bus.f_gnt    = f_gnt;
  assign bus.l_gnt    = l_gnt;
  assign bus.f_rvalid = f_rvalid;
  assign bus.l_rvalid = l_rvalid;
  assign bus.f_rdata  = f_rdata;
  assign bus.l_rdata  = l_rdata;
  assign bus.im_addr  = im_addr;
  assign bus.im_we    = im_we;
  assign bus.im_wdata = im_wdata;

endmodule

// File: tb/tb_im_arbiter.sv
// Self-checking bench for im_arbiter: a vector table plus hand-written
// sequences for reset, contention and burst behaviour. Expected read data
// comes from a bench-side shadow memory and flows through per-port queues.
module tb_im_arbiter;
  import im_arb_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic          fr;
    logic [AW-1:0] fa;
    logic          lr;
    logic          lw;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic          ef;
    logic          el;
    string         nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  im_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  im_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    if (a == 10'h003) return 32'h3C010001;
    return {6'h2A, a, 6'h15, a};
  endfunction

  // Memory array model: unwritten words read back as pat(addr).
  logic [DW-1:0] mem [0:DEPTH-1];
  bit            wr_mask [0:DEPTH-1];
  assign bus.im_rdata = wr_mask[bus.im_addr] ? mem[bus.im_addr] : pat(bus.im_addr);
  always @(posedge clk) begin
    if (bus.im_we) begin
      mem[bus.im_addr]     <= bus.im_wdata;
      wr_mask[bus.im_addr] <= 1'b1;
    end
  end

  logic [DW-1:0] shadow [0:DEPTH-1];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] lq[$];
  logic [DW-1:0] exp_frd;
  logic [DW-1:0] exp_lrd;
  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic fr, input logic [AW-1:0] fa,
                              input logic lr, input logic lw, input logic [AW-1:0] la,
                              input logic [DW-1:0] ld, input logic ef, input logic el,
                              input string nm);
    vec_t v;
    v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.ef = ef; v.el = el; v.nm = nm;
    return v;
  endfunction

  task automatic drive_idle();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
  endtask

  task automatic clear_sb();
    fq.delete();
    lq.delete();
    exp_frd = '0;
    exp_lrd = '0;
  endtask

  // One clock cycle: drive, check grant/memory lines, then check read returns.
  task automatic cyc(input vec_t v);
    logic [AW-1:0] ea;
    logic          efv;
    logic          elv;
    @(negedge clk);
    bus.f_req   = v.fr;
    bus.f_addr  = v.fa;
    bus.l_req   = v.lr;
    bus.l_we    = v.lw;
    bus.l_addr  = v.la;
    bus.l_wdata = v.ld;
    #1;
    chk1({v.nm, " f_gnt"}, bus.f_gnt, v.ef);
    chk1({v.nm, " l_gnt"}, bus.l_gnt, v.el);
    ea = v.ef ? v.fa : (v.el ? v.la : '0);
    chkw({v.nm, " im_addr"}, DW'(bus.im_addr), DW'(ea));
    chk1({v.nm, " im_we"}, bus.im_we, v.el & v.lw);
    if (v.el && v.lw)  chkw({v.nm, " im_wdata"}, bus.im_wdata, v.ld);
    if (!v.ef && !v.el) chkw({v.nm, " im_wdata idle"}, bus.im_wdata, '0);
    if (v.ef)           fq.push_back(shadow[v.fa]);
    if (v.el && !v.lw)  lq.push_back(shadow[v.la]);
    efv = v.ef;
    elv = v.el & ~v.lw;
    @(posedge clk);
    if (v.el && v.lw) shadow[v.la] = v.ld;
    #1;
    chk1({v.nm, " f_rvalid"}, bus.f_rvalid, efv);
    chk1({v.nm, " l_rvalid"}, bus.l_rvalid, elv);
    if (efv) begin
      chk1({v.nm, " f queue"}, fq.size() != 0, 1'b1);
      if (fq.size() != 0) exp_frd = fq.pop_front();
    end
    if (elv) begin
      chk1({v.nm, " l queue"}, lq.size() != 0, 1'b1);
      if (lq.size() != 0) exp_lrd = lq.pop_front();
    end
    chkw({v.nm, " f_rdata"}, bus.f_rdata, exp_frd);
    chkw({v.nm, " l_rdata"}, bus.l_rdata, exp_lrd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [11];
    string seq;

    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = pat(AW'(i));
    clear_sb();
    drive_idle();

    // Power-on reset.
    reset = 1'b0;
    #12;
    chk1("por f_rvalid", bus.f_rvalid, 1'b0);
    chk1("por l_rvalid", bus.l_rvalid, 1'b0);
    chkw("por f_rdata", bus.f_rdata, '0);
    chkw("por l_rdata", bus.l_rdata, '0);
    chk1("por im_we", bus.im_we, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    //           fr    fa       lr    lw    la       ld            ef    el
    tbl[0]  = mk(1'b1, 10'h003, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, "v0 fetch3");
    tbl[1]  = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b0, "v1 idle");
    tbl[2]  = mk(1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 32'h24020005, 1'b0, 1'b1, "v2 lwrite");
    tbl[3]  = mk(1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, "v3 fraw");
    tbl[4]  = mk(1'b0, 10'h000, 1'b1, 1'b0, 10'h010, 32'h0,        1'b0, 1'b1, "v4 lread");
    tbl[5]  = mk(1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 32'h11112222, 1'b0, 1'b1, "v5 lwrite");
    tbl[6]  = mk(1'b1, 10'h020, 1'b1, 1'b0, 10'h005, 32'h0,        1'b0, 1'b1, "v6 both");
    tbl[7]  = mk(1'b1, 10'h020, 1'b1, 1'b0, 10'h006, 32'h0,        1'b0, 1'b1, "v7 both");
    tbl[8]  = mk(1'b1, 10'h020, 1'b1, 1'b0, 10'h007, 32'h0,        1'b1, 1'b0, "v8 both");
    tbl[9]  = mk(1'b0, 10'h000, 1'b1, 1'b0, 10'h007, 32'h0,        1'b0, 1'b1, "v9 lread");
    tbl[10] = mk(1'b0, 10'h000, 1'b1, 1'b0, 10'h009, 32'h0,        1'b0, 1'b1, "v10 lread");
    for (int i = 0; i < 11; i++) cyc(tbl[i]);

    // Asynchronous reset mid-cycle while l_rvalid is high and a write is requested.
    @(negedge clk);
    drive_idle();
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 10'h3FF;
    bus.l_wdata = '1;
    #2 reset = 1'b0;
    #1;
    chk1("mid f_rvalid", bus.f_rvalid, 1'b0);
    chk1("mid l_rvalid", bus.l_rvalid, 1'b0);
    chkw("mid f_rdata", bus.f_rdata, '0);
    chkw("mid l_rdata", bus.l_rdata, '0);
    chk1("mid im_we", bus.im_we, 1'b0);
    chkw("mid im_addr", DW'(bus.im_addr), '0);
    chk1("mid l_gnt", bus.l_gnt, 1'b0);
    clear_sb();
    @(posedge clk);
    #1;
    chk1("mid hold im_we", bus.im_we, 1'b0);
    chk1("mid hold l_rvalid", bus.l_rvalid, 1'b0);
    @(negedge clk);
    drive_idle();
    #2 reset = 1'b1;

    // Continuous contention from reset.
    seq = "FFFFLLLLFF";
    for (int i = 0; i < 10; i++)
      cyc(mk(1'b1, 10'h040, 1'b1, 1'b0, 10'h041, '0,
             seq[i] == "F", seq[i] == "L", $sformatf("contend%0d", i)));

    // Burst counter clears on an idle cycle.
    for (int i = 0; i < 3; i++)
      cyc(mk(1'b1, AW'(10'h050 + i), 1'b0, 1'b0, 10'h000, '0, 1'b1, 1'b0, $sformatf("fonly%0d", i)));
    cyc(mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, '0, 1'b0, 1'b0, "gap"));
    seq = "FFFFL";
    for (int i = 0; i < 5; i++)
      cyc(mk(1'b1, AW'(10'h060 + i), 1'b1, 1'b0, 10'h070, '0,
             seq[i] == "F", seq[i] == "L", $sformatf("reburst%0d", i)));

    // Reset while a granted fetch read is still pending.
    @(negedge clk);
    drive_idle();
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h003;
    #1;
    chk1("pend f_gnt", bus.f_gnt, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("pend f_gnt in reset", bus.f_gnt, 1'b0);
    clear_sb();
    @(posedge clk);
    #1;
    chk1("pend f_rvalid edge", bus.f_rvalid, 1'b0);
    @(negedge clk);
    drive_idle();
    #2 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("pend f_rvalid after%0d", i), bus.f_rvalid, 1'b0);
      chkw($sformatf("pend f_rdata after%0d", i), bus.f_rdata, '0);
    end

    // Normal fetch after recovery; both requesting, F has priority from reset.
    cyc(mk(1'b1, 10'h003, 1'b1, 1'b0, 10'h010, '0, 1'b1, 1'b0, "post both"));
    cyc(mk(1'b0, 10'h000, 1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b1, "post lread"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_arbiter.md
# im_arbiter

Shares the single-ported instruction memory between two requesters: the instruction-fetch stage (port F) and the program loader/debug port (port L, read and write). Each cycle it grants at most one access, drives the memory address/write lines, and returns read data one cycle later. Arbitration is last-owner-sticky with a bounded burst, so neither side can starve the other. Sits between the IF stage, the loader, and the memory array.

## Interface
- ADDR_W, 10, word address width (byte address bits [11:2])
- DATA_W, 32, instruction word width
- MAX_BURST, 4, max consecutive grants to one port while the other is waiting (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request; held until f_gnt
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  f_rdata valid (one-cycle pulse)
- f_rdata  out  DATA_W  fetch read data
- l_req  in  1  loader request; held until l_gnt
- l_we  in  1  1 = write, 0 = read
- l_addr  in  ADDR_W  loader word address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader granted this cycle
- l_rvalid  out  1  l_rdata valid (reads only)
- l_rdata  out  DATA_W  loader read data
- im_addr  out  ADDR_W  memory word address
- im_we  out  1  memory write enable
- im_wdata  out  DATA_W  memory write data
- im_rdata  in  DATA_W  memory combinational read data

## Operation
- State: last ∈ {F, L} (last granted port); cnt, 0..MAX_BURST (consecutive grants to last, saturating).
- Grant, combinational from req/state:
  - Neither requesting: no grant.
  - Exactly one requesting: that port is granted.
  - Both requesting: last is granted if cnt < MAX_BURST; otherwise the other port is granted.
- State update at each edge:
  - Granted port == last: cnt = min(cnt+1, MAX_BURST).
  - Granted port ≠ last: last = granted, cnt = 1.
  - No grant: cnt = 0; last unchanged.
- Memory drive:
  - Granted port's address goes to im_addr.
  - im_we = l_gnt & l_we.
  - im_wdata = l_wdata.
  - With no grant: im_addr = 0, im_we = 0, im_wdata = 0.
- Read capture: on a granted read, im_rdata is registered into that port's rdata register and its rvalid pulses next cycle.
- Writes: complete at the grant edge; no rvalid.
- Each port's rdata holds its last value until overwritten.
- Read-after-write to the same address in the next cycle returns the new data.

## Timing
- Reset (asynchronous, reset = 0) forces:
  - last = F, cnt = 0.
  - f_rvalid = l_rvalid = 0, f_rdata = l_rdata = 0.
  - While reset = 0: no grants, so im_we = 0 and im_addr = 0.
- Grant latency: 0 cycles (same cycle as req) when uncontended.
- Read data latency: rvalid exactly 1 cycle after gnt, for 1 cycle.
- Back-to-back grants to one port give back-to-back rvalid pulses.
- Worst-case wait while the other port holds continuous requests: MAX_BURST cycles.
- Requester must hold req, addr, we and wdata stable until gnt. Changing them before gnt is undefined.
- Reset asserted while a read is pending: the pending rvalid is dropped and does not appear after release.

## Structure
- Package im_arb_pkg: port enum (PORT_F, PORT_L), ADDR_W/DATA_W defaults.
- Sub-module im_arb_core: owns last/cnt and the grant decision (inputs f_req, l_req; outputs f_gnt, l_gnt).
- Top level: memory mux, read-data registers and rvalid flops.

## Test plan
- Reset: assert reset = 0 mid-cycle → immediately f_rvalid = l_rvalid = 0, rdata = 0, im_we = 0. After release with l_req = f_req = 1 and MAX_BURST = 4 → f_gnt first.
- Fetch only: f_req, f_addr = 0x003, mem[3] = 0x3C010001 → f_gnt same cycle, then f_rvalid = 1 and f_rdata = 0x3C010001 next cycle, l_gnt = 0 throughout.
- Write then read: l_we = 1, l_addr = 0x010, l_wdata = 0x24020005 (im_we = 1 that cycle), then f read 0x010 → f_rdata = 0x24020005.
- Contention: MAX_BURST = 4, both request continuously for 10 cycles from reset → grant sequence F F F F L L L L F F, with an rvalid following each.
- Idle reset of burst: F granted 3 times, 1 idle cycle, then both request → F granted 4 more times before first L.
- Reset during pending read: f granted at edge k, reset = 0 before edge k+1 → f_rvalid stays 0 through and after release.
